// File: rtl/ram_seq.sv
// ram_seq: write-stream to RAM sequencer with a buffered readback burst engine.
// Writes stream into consecutive RAM addresses while idle. A readback burst
// then drains a run of addresses into a single-entry output register.
//
// Handshake semantics (both streams): a word transfers on a rising clk edge
// where valid and ready are both 1. A producer holding valid=1 keeps its data
// stable until that edge. rd_valid/rd_data stay frozen while rd_ready=0.
module ram_seq #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 8
) (
  input  logic              clk,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_go,
  input  logic [ADR_W-1:0]  rd_base,
  input  logic [ADR_W:0]    rd_len,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              busy,
  output logic [ADR_W:0]    wr_count,
  output logic              ram_we,
  output logic [ADR_W-1:0]  ram_adr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  // Count saturates at the RAM depth (2^ADR_W).
  localparam logic [ADR_W:0] CNT_MAX = {1'b1, {ADR_W{1'b0}}};

  state_t             state;
  logic [ADR_W-1:0]   wr_ptr;
  logic [ADR_W-1:0]   rd_ptr;
  logic [ADR_W:0]     remaining;

  logic wr_fire;
  logic go_fire;
  logic out_free;
  logic load;
  logic finish;

  // The state register itself is visible to checkers through busy.
  assign busy     = (state == DRAIN);
  // A reset cycle must never look like it accepts a word.
  assign wr_ready = (state == IDLE) && !start;
  assign wr_fire  = wr_valid && wr_ready;
  assign ram_we   = wr_fire;
  assign ram_din  = wr_data;
  // The RAM port is shared: write pointer while idle, read pointer while draining.
  assign ram_adr  = busy ? rd_ptr : wr_ptr;

  // Zero-length requests are dropped; requests during a burst are ignored.
  assign go_fire  = (state == IDLE) && rd_go && (rd_len != '0);
  // Output register can take a new word when empty or being consumed now.
  assign out_free = !rd_valid || rd_ready;
  assign load     = busy && (remaining != '0) && out_free;
  assign finish   = busy && (remaining == '0) && out_free;

  // Single sequential block: write pointer/count, burst FSM and output register.
  always_ff @(posedge clk) begin
    if (start) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      wr_count  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_count != CNT_MAX) begin
          wr_count <= wr_count + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          // A write in this same cycle commits to RAM at this edge, so the
          // burst starting next cycle reads it back.
          if (go_fire) begin
            rd_ptr    <= rd_base;
            remaining <= rd_len;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (load) begin
            rd_data   <= ram_dout;
            rd_valid  <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end else if (finish) begin
            rd_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq.sv
// tb_ram_seq: randomized bench for ram_seq with a RAM behavioural model,
// an address-level reference memory and an expected-word queue.
module tb_ram_seq;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 8;
  localparam int DEPTH  = 256;

  logic              clk;
  logic              start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_go;
  logic [ADR_W-1:0]  rd_base;
  logic [ADR_W:0]    rd_len;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              busy;
  logic [ADR_W:0]    wr_count;
  logic              ram_we;
  logic [ADR_W-1:0]  ram_adr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  ram_seq #(.DATA_W(DATA_W), .ADR_W(ADR_W)) dut (
    .clk      (clk),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_go    (rd_go),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .busy     (busy),
    .wr_count (wr_count),
    .ram_we   (ram_we),
    .ram_adr  (ram_adr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // ---------------- clock / RAM environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  assign ram_dout = mem[ram_adr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_adr] <= ram_din;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q [$];
  int exp_wr_ptr;
  int exp_cnt;
  int n_total;
  int n_bad;
  bit pat [7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Consumer-side monitor: every accepted word must be the next expected one,
  // and a stalled word must be repeated unchanged.
  bit                mon_stall;
  logic [DATA_W-1:0] mon_data;
  always @(negedge clk) begin
    if (start) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", rd_data, mon_data);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) chk("extra_word_qsize", 32'(exp_q.size()), 32'd1);
        else chk("rd_data", rd_data, exp_q.pop_front());
      end
      mon_stall = rd_valid && !rd_ready;
      mon_data  = rd_data;
    end
  end

  function automatic bit ready_val(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[(k - 1) % 7];
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    start = 1'b1; wr_valid = 1'b1; wr_data = 32'hdead_beef;
    rd_go = 1'b1; rd_base = 8'd3; rd_len = 9'd4;
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; wr_valid = 1'b0; rd_go = 1'b0;
    exp_wr_ptr = 0; exp_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_wr_ready_after", 32'(wr_ready), 32'd1);
  endtask

  task automatic model_write(input logic [DATA_W-1:0] d);
    ref_mem[exp_wr_ptr] = d;
    exp_wr_ptr = (exp_wr_ptr + 1) % DEPTH;
    if (exp_cnt < DEPTH) exp_cnt++;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = d; rd_go = 1'b0;
    @(negedge clk);
    chk("wr_ready", 32'(wr_ready), 32'd1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_adr", 32'(ram_adr), 32'(exp_wr_ptr));
    chk("wr_ram_din", ram_din, d);
    model_write(d);
  endtask

  task automatic do_burst(input int base, input int len, input int mode, input bit timing,
                          input bit go_again, input bit with_write, input logic [DATA_W-1:0] wdata);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    rd_go = 1'b1; rd_base = ADR_W'(base); rd_len = 9'(len);
    wr_valid = with_write; wr_data = wdata; rd_ready = 1'b1;
    @(negedge clk);
    chk("go_busy_before", 32'(busy), 32'd0);
    if (with_write) begin
      chk("go_wr_ready", 32'(wr_ready), 32'd1);
      chk("go_ram_adr", 32'(ram_adr), 32'(exp_wr_ptr));
      model_write(wdata);
    end
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % DEPTH]);
    for (int k = 1; k <= 4 * len + 20; k++) begin
      @(posedge clk); #1;
      wr_valid = 1'b0;
      rd_go = go_again && (k == 2);
      if (go_again) begin rd_base = 8'd100; rd_len = 9'd9; end
      rd_ready = ready_val(mode, k);
      @(negedge clk);
      if (busy) begin
        chk("drain_wr_ready", 32'(wr_ready), 32'd0);
        chk("drain_ram_we", 32'(ram_we), 32'd0);
        chk("drain_wr_count", 32'(wr_count), 32'(exp_cnt));
      end
      if (len == 0) begin
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_rd_valid", 32'(rd_valid), 32'd0);
      end
      if (timing && len > 0) begin
        if (k == 1) begin
          chk("lat_first_invalid", 32'(rd_valid), 32'd0);
          chk("lat_busy", 32'(busy), 32'd1);
        end else if (k <= len + 1) begin
          chk("lat_valid", 32'(rd_valid), 32'd1);
        end else if (k == len + 2) begin
          chk("lat_idle", 32'(busy), 32'd0);
          chk("lat_idle_valid", 32'(rd_valid), 32'd0);
        end
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    rd_go = 1'b0;
    chk("burst_finished", 32'(done), 32'd1);
    chk("burst_words_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_total = 0; n_bad = 0;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    mon_stall = 1'b0; mon_data = '0;
    start = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_go = 1'b0; rd_base = '0; rd_len = '0; rd_ready = 1'b1;
    exp_wr_ptr = 0; exp_cnt = 0;

    do_reset();

    // Basic write then full-rate readback with latency checks.
    write_word(32'h11); write_word(32'h22); write_word(32'h33); write_word(32'h44);
    do_burst(0, 4, 0, 1'b1, 1'b0, 1'b0, '0);
    chk("wr_count_4", 32'(wr_count), 32'd4);

    // Same burst with a stalling consumer.
    do_burst(0, 4, 1, 1'b0, 1'b0, 1'b0, '0);

    // Zero-length request is ignored; request during a burst is ignored.
    do_burst(3, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    do_burst(0, 4, 0, 1'b1, 1'b1, 1'b0, '0);

    // Same-cycle write and burst start at address 5.
    do_reset();
    for (int i = 0; i < 5; i++) write_word($urandom);
    do_burst(5, 1, 0, 1'b1, 1'b0, 1'b1, 32'hAA);

    // Wrap-around of the write pointer and saturation of the count.
    do_reset();
    for (int k = 0; k < 258; k++) write_word(32'(k));
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_count_sat", 32'(wr_count), 32'd256);
    chk("ref_wrap_254", ref_mem[254], 32'd254);
    chk("ref_wrap_0", ref_mem[0], 32'd256);
    do_burst(254, 4, 0, 1'b1, 1'b0, 1'b0, '0);

    // Randomized writes, bursts and consumer stalls.
    for (int r = 0; r < 14; r++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int i = 0; i < nw; i++) write_word($urandom);
      do_burst($urandom_range(0, 255), $urandom_range(1, 16), 2, 1'b0, 1'b0,
               1'($urandom_range(0, 1)), $urandom);
    end
    do_burst($urandom_range(0, 255), 256, 2, 1'b0, 1'b0, 1'b0, '0);
    do_burst($urandom_range(0, 255), 256, 0, 1'b1, 1'b0, 1'b0, '0);

    // Reset in the middle of a len-8 burst.
    for (int i = 0; i < 8; i++) write_word($urandom);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_go = 1'b1; rd_base = 8'd0; rd_len = 9'd8; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(ref_mem[i]);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      rd_go = 1'b0;
      if (k == 3) begin start = 1'b1; rd_ready = 1'b0; wr_valid = 1'b1; end
      @(negedge clk);
      if (k == 3) begin
        chk("abort_rd_valid_before", 32'(rd_valid), 32'd1);
        chk("abort_second_word", rd_data, ref_mem[1]);
        chk("abort_wr_ready", 32'(wr_ready), 32'd0);
        chk("abort_ram_we", 32'(ram_we), 32'd0);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
    exp_q.delete(); exp_wr_ptr = 0; exp_cnt = 0;
    @(negedge clk);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_count", 32'(wr_count), 32'd0);
    chk("abort_wr_ready_after", 32'(wr_ready), 32'd1);
    chk("abort_rd_data", rd_data, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(rd_valid), 32'd0);
    end
    write_word(32'h5A5A_0001);
    do_burst(0, 1, 0, 1'b1, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
